// File: rtl/clk_en_pkg.sv
// Shared types and sizing helpers for the clock-enable capture bank.
package clk_en_pkg;

   typedef enum logic [1:0] {OFF, LOCKING, RUN} state_e;

   // Lock counter runs 0..lock_cycles-1.
   function automatic int lock_cnt_w(input int lock_cycles);
      return (lock_cycles < 2) ? 1 : $clog2(lock_cycles);
   endfunction

   // One code past the last channel must be representable so stray writes can be flagged.
   function automatic int chan_idx_w(input int n_ch);
      return (n_ch < 2) ? 1 : $clog2(n_ch + 1);
   endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One clock-enable channel: divide counter, deferred ratio update and capture flop.
module clk_en_chan #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_i,
   input  logic             go_i,
   input  logic             wr_i,
   input  logic [DIV_W-1:0] wr_div_i,
   input  logic             din_i,
   output logic             ce_o,
   output logic             dout_o,
   output logic             pend_o
);

   logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d, pdiv_q, pdiv_d;
   logic             pend_q, pend_d, dout_q, dout_d;
   logic             restart;

   assign ce_o   = run_i && (div_q != '0) && (cnt_q == div_q - DIV_W'(1));
   assign dout_o = dout_q;
   assign pend_o = pend_q;

   // Pending ratios only land where a period ends, so no period is ever cut short.
   assign restart = !go_i || (div_q == '0) || ce_o;

   always_comb begin
      div_d  = div_q;
      cnt_d  = cnt_q;
      pdiv_d = pdiv_q;
      pend_d = pend_q;
      dout_d = dout_q;
      if (ce_o) dout_d = din_i;
      cnt_d = restart ? '0 : cnt_q + DIV_W'(1);
      if (pend_q && restart) begin
         div_d  = pdiv_q;
         pend_d = 1'b0;
      end
      if (wr_i) begin
         pdiv_d = wr_div_i;
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= DIV_W'(DEFAULT_DIV);
         cnt_q  <= '0;
         pdiv_q <= '0;
         pend_q <= 1'b0;
         dout_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         pdiv_q <= pdiv_d;
         pend_q <= pend_d;
         dout_q <= dout_d;
      end
   end

endmodule

// File: rtl/clk_en_capture_bank.sv
// Bank of phase-aligned clock-enable channels behind a PLL-style enable/lock sequence.
module clk_en_capture_bank
   import clk_en_pkg::*;
#(
   parameter int N_CH        = 8,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 1,
   parameter int LOCK_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en_i,
   output logic                          lock_o,
   input  logic [N_CH-1:0]               din_i,
   output logic [N_CH-1:0]               dout_o,
   output logic [N_CH-1:0]               ce_o,
   input  logic                          cfg_valid_i,
   output logic                          cfg_ready_o,
   input  logic [chan_idx_w(N_CH)-1:0]   cfg_ch_i,
   input  logic [DIV_W-1:0]              cfg_div_i,
   output logic                          cfg_err_o
);

   localparam int CHW = chan_idx_w(N_CH);
   localparam int LCW = lock_cnt_w(LOCK_CYCLES);

   state_e          state_q, state_d;
   logic [LCW-1:0]  lcnt_q, lcnt_d;
   logic            cfg_err_q, cfg_err_d;
   logic [N_CH-1:0] pend, wr;
   logic            run, go, cfg_fire;

   assign run         = (state_q == RUN);
   assign go          = run && en_i;
   assign lock_o      = run;
   assign cfg_ready_o = ~|pend;
   assign cfg_fire    = cfg_valid_i && cfg_ready_o;
   assign cfg_err_o   = cfg_err_q;

   always_comb begin
      state_d   = state_q;
      lcnt_d    = '0;
      cfg_err_d = cfg_fire && (int'(cfg_ch_i) >= N_CH);
      unique case (state_q)
         OFF:     if (en_i) state_d = LOCKING;
         LOCKING: begin
            if (lcnt_q == LCW'(LOCK_CYCLES - 1)) state_d = RUN;
            else                                 lcnt_d  = lcnt_q + LCW'(1);
         end
         RUN:     state_d = RUN;
         default: state_d = OFF;
      endcase
      if (!en_i) begin
         state_d = OFF;
         lcnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= OFF;
         lcnt_q    <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lcnt_q    <= lcnt_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign wr[i] = cfg_fire && (cfg_ch_i == CHW'(i));
      clk_en_chan #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .run_i    (run),
         .go_i     (go),
         .wr_i     (wr[i]),
         .wr_div_i (cfg_div_i),
         .din_i    (din_i[i]),
         .ce_o     (ce_o[i]),
         .dout_o   (dout_o[i]),
         .pend_o   (pend[i])
      );
   end

endmodule

// File: tb/tb_clk_en_capture_bank.sv
// Directed bench: per-cycle scoreboard from a behavioural model plus fixed-value spot checks.
module tb_clk_en_capture_bank;

   localparam int N  = 8;
   localparam int DW = 8;
   localparam int LC = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          cfg_valid = 1'b0;
   logic [N-1:0]  din = '0;
   logic [3:0]    cfg_ch = '0;
   logic [DW-1:0] cfg_div = '0;
   logic          lock, cfg_ready, cfg_err;
   logic [N-1:0]  dout, ce;

   always #5 clk = ~clk;

   clk_en_capture_bank #(
      .N_CH(N), .DIV_W(DW), .DEFAULT_DIV(1), .LOCK_CYCLES(LC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en_i        (en),
      .lock_o      (lock),
      .din_i       (din),
      .dout_o      (dout),
      .ce_o        (ce),
      .cfg_valid_i (cfg_valid),
      .cfg_ready_o (cfg_ready),
      .cfg_ch_i    (cfg_ch),
      .cfg_div_i   (cfg_div),
      .cfg_err_o   (cfg_err)
   );

   typedef struct packed {
      logic         lock;
      logic [N-1:0] ce;
      logic [N-1:0] dout;
      logic         ready;
      logic         err;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc_n = 0;

   // Behavioural model state: st 0=OFF 1=LOCKING 2=RUN.
   int            m_st, m_lcnt;
   logic [DW-1:0] m_div[N], m_cnt[N], m_pdiv[N];
   logic [N-1:0]  m_pend, m_dout;
   logic          m_err;

   function automatic logic [N-1:0] m_ce();
      logic [N-1:0] c;
      for (int i = 0; i < N; i++)
         c[i] = (m_st == 2) && (m_div[i] != 0) && (int'(m_cnt[i]) == int'(m_div[i]) - 1);
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: observed 0x%0h expected 0x%0h", tag, cyc_n, got, exp);
      end
   endtask

   // Advance the model on the inputs about to be sampled and queue the outputs it predicts.
   task automatic model_step();
      logic [N-1:0] c;
      logic         rdy, running, endp;
      exp_t         e;
      c       = m_ce();
      rdy     = (m_pend == '0);
      running = (m_st == 2) && en;
      if (rst) begin
         m_st = 0; m_lcnt = 0; m_pend = '0; m_dout = '0; m_err = 1'b0;
         for (int i = 0; i < N; i++) begin
            m_div[i] = 8'd1; m_cnt[i] = '0; m_pdiv[i] = '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            endp = !running || (m_div[i] == 0) || c[i];
            if (c[i]) m_dout[i] = din[i];
            m_cnt[i] = endp ? 8'd0 : m_cnt[i] + 8'd1;
            if (m_pend[i] && endp) begin
               m_div[i] = m_pdiv[i]; m_pend[i] = 1'b0;
            end
            if (cfg_valid && rdy && int'(cfg_ch) == i) begin
               m_pdiv[i] = cfg_div; m_pend[i] = 1'b1;
            end
         end
         m_err = cfg_valid && rdy && (int'(cfg_ch) >= N);
         if (!en) begin
            m_st = 0; m_lcnt = 0;
         end else if (m_st == 0) begin
            m_st = 1;
         end else if (m_st == 1) begin
            if (m_lcnt == LC - 1) begin m_st = 2; m_lcnt = 0; end
            else m_lcnt++;
         end
      end
      e.lock = (m_st == 2); e.ce = m_ce(); e.dout = m_dout;
      e.ready = (m_pend == '0); e.err = m_err;
      sb.push_back(e);
   endtask

   task automatic cyc();
      exp_t e;
      model_step();
      @(posedge clk);
      #1;
      cyc_n++;
      if (sb.size() == 0) begin
         n_chk++; n_fail++;
         $error("FAIL sb_empty cycle %0d: observed 0 entries expected 1", cyc_n);
      end else begin
         e = sb.pop_front();
         chk("sb_lock", 32'(lock), 32'(e.lock));
         chk("sb_ce", 32'(ce), 32'(e.ce));
         chk("sb_dout", 32'(dout), 32'(e.dout));
         chk("sb_ready", 32'(cfg_ready), 32'(e.ready));
         chk("sb_err", 32'(cfg_err), 32'(e.err));
      end
   endtask

   initial begin
      bit found;
      // Reset state
      cyc(); cyc();
      chk("rst_lock", 32'(lock), 0);
      chk("rst_ce", 32'(ce), 0);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_ready", 32'(cfg_ready), 1);
      chk("rst_err", 32'(cfg_err), 0);

      // Lock latency with default divide of 1
      rst = 1'b0; en = 1'b1; din = 8'hA5;
      for (int k = 0; k < 22; k++) begin
         if (k == 18) din = 8'h3C;
         cyc();
         if (k == 15) chk("lock_c16", 32'(lock), 0);
         if (k == 16) begin
            chk("lock_c17", 32'(lock), 1);
            chk("ce_c17", 32'(ce), 32'hFF);
         end
         if (k == 17) chk("dout_a5", 32'(dout), 32'hA5);
         if (k == 18) chk("dout_3c", 32'(dout), 32'h3C);
      end

      // Program ch0..3 with ratios 1..4 while off
      en = 1'b0;
      cyc();
      chk("off_lock", 32'(lock), 0);
      chk("off_ce", 32'(ce), 0);
      for (int c = 0; c < 4; c++) begin
         cfg_valid = 1'b1; cfg_ch = 4'(c); cfg_div = 8'(c + 1);
         cyc();
         cfg_valid = 1'b0;
         cyc();
      end
      en = 1'b1; din = 8'hFF;
      for (int k = 0; k < 17; k++) cyc();
      chk("run0_ce", 32'(ce), 32'hF1);
      for (int r = 1; r < 13; r++) begin
         if (r == 5) din = 8'h00;
         cyc();
         if (r == 3) chk("run3_ce", 32'(ce), 32'hFB);
      end

      // ch2 to ratio 4, then retarget to 2 while cnt=1
      cfg_valid = 1'b1; cfg_ch = 4'd2; cfg_div = 8'd4;
      cyc();
      cfg_valid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (m_pend == '0 && m_div[2] == 8'd4 && m_cnt[2] == 8'd1) begin
            found = 1'b1;
            break;
         end
         cyc();
      end
      chk("ch2_align_found", 32'(found), 1);
      cfg_valid = 1'b1; cfg_ch = 4'd2; cfg_div = 8'd2;
      cyc();
      cfg_valid = 1'b0;
      chk("sw_ready_a", 32'(cfg_ready), 0);
      chk("sw_ce2_a", 32'(ce[2]), 0);
      cyc();
      chk("sw_ready_b", 32'(cfg_ready), 0);
      chk("sw_ce2_b", 32'(ce[2]), 1);
      cyc();
      chk("sw_ready_c", 32'(cfg_ready), 1);
      chk("sw_ce2_c", 32'(ce[2]), 0);
      cyc();
      chk("sw_ce2_d", 32'(ce[2]), 1);
      cyc();
      chk("sw_ce2_e", 32'(ce[2]), 0);
      cyc();
      chk("sw_ce2_f", 32'(ce[2]), 1);

      // Out-of-range channel
      cfg_valid = 1'b1; cfg_ch = 4'd9; cfg_div = 8'd7;
      cyc();
      cfg_valid = 1'b0;
      chk("bad_err", 32'(cfg_err), 1);
      chk("bad_ready", 32'(cfg_ready), 1);
      cyc();
      chk("bad_err_clr", 32'(cfg_err), 0);
      for (int k = 0; k < 6; k++) cyc();

      // Drop en mid-run, then relock
      din = 8'h5A;
      cyc();
      en = 1'b0;
      cyc();
      chk("drop_lock", 32'(lock), 0);
      chk("drop_ce", 32'(ce), 0);
      din = 8'hC3;
      for (int k = 0; k < 3; k++) cyc();
      en = 1'b1;
      for (int k = 0; k < 17; k++) begin
         cyc();
         if (k == 15) chk("relock_c16", 32'(lock), 0);
         if (k == 16) chk("relock_c17", 32'(lock), 1);
      end
      for (int k = 0; k < 5; k++) cyc();

      // ch5 disabled, then re-enabled with ratio 3
      cfg_valid = 1'b1; cfg_ch = 4'd5; cfg_div = 8'd0;
      cyc();
      cfg_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("ch5_off", 32'(ce[5]), 0);
      end
      cfg_valid = 1'b1; cfg_ch = 4'd5; cfg_div = 8'd3;
      cyc();
      cfg_valid = 1'b0;
      chk("ch5_pend_ready", 32'(cfg_ready), 0);
      cyc();
      chk("ch5_cnt0", 32'(ce[5]), 0);
      cyc();
      chk("ch5_cnt1", 32'(ce[5]), 0);
      cyc();
      chk("ch5_cnt2", 32'(ce[5]), 1);
      cyc(); cyc(); cyc();
      chk("ch5_cnt2_again", 32'(ce[5]), 1);

      // Reset mid-sequence
      din = 8'hFF;
      cfg_valid = 1'b1; cfg_ch = 4'd1; cfg_div = 8'd5;
      cyc();
      cfg_valid = 1'b0;
      rst = 1'b1;
      cyc();
      chk("mrst_lock", 32'(lock), 0);
      chk("mrst_ce", 32'(ce), 0);
      chk("mrst_dout", 32'(dout), 0);
      chk("mrst_ready", 32'(cfg_ready), 1);
      chk("mrst_err", 32'(cfg_err), 0);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
